// File: rtl/pr_boundary_slice_if.sv
// Multi-channel valid/ready stream bundle for the PR boundary slice.
// Channel i occupies data bits [i*DATA_WIDTH +: DATA_WIDTH].
interface pr_boundary_slice_if #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned DATA_WIDTH = 128
);
    logic [CHANNELS*DATA_WIDTH-1:0] data;
    logic [CHANNELS-1:0]            valid;
    logic [CHANNELS-1:0]            ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/pr_boundary_slice.sv
// Multi-channel skid-register slice for streams crossing a PR region boundary.
// A decouple controller drains in-flight beats, with a timeout, and then isolates the boundary.
module pr_boundary_slice #(
    parameter int unsigned DATA_WIDTH    = 128,
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned REG_LENGTH    = 2,
    parameter int unsigned DRAIN_TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    pr_boundary_slice_if.slave         s,
    pr_boundary_slice_if.master        m,
    input  logic                       decouple_req,
    output logic                       decouple_ack,
    output logic                       drain_timeout,
    output logic [CHANNELS-1:0]        busy
);
    localparam int unsigned CNT_W = $clog2(DRAIN_TIMEOUT);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_ISOLATED} state_t;

    state_t                                               state;
    logic [CNT_W-1:0]                                     drain_cnt;
    logic [CHANNELS-1:0]                                  s_ready_q;
    logic [CHANNELS-1:0][REG_LENGTH-1:0]                  main_v, skid_v, main_v_n, skid_v_n;
    logic [CHANNELS-1:0][REG_LENGTH-1:0][DATA_WIDTH-1:0]  main_d, skid_d, main_d_n, skid_d_n;
    logic [CHANNELS-1:0]                                  busy_n, skid0_n;
    logic                                                 pipe_empty_c;
    logic                                                 timeout_hit_c;
    logic                                                 flush_c;

    assign pipe_empty_c  = ~|{main_v, skid_v};
    assign timeout_hit_c = (drain_cnt == CNT_W'(DRAIN_TIMEOUT - 1));
    // Empty wins over the timeout; dropping the request aborts the drain without a flush.
    assign flush_c       = (state == ST_DRAIN) && decouple_req && !pipe_empty_c && timeout_hit_c;

    // Per-stage next state: stage j is fed by stage j-1 (or s) and drained by stage j+1 (or m).
    always_comb begin : p_stage_next
        logic [REG_LENGTH:0]                 feed_v;
        logic [REG_LENGTH:0]                 up_rdy;
        logic [REG_LENGTH:0][DATA_WIDTH-1:0] feed_d;
        main_v_n = main_v;
        skid_v_n = skid_v;
        main_d_n = main_d;
        skid_d_n = skid_d;
        feed_v   = '0;
        up_rdy   = '0;
        feed_d   = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            for (int j = 0; j < int'(REG_LENGTH); j++) begin
                up_rdy[j] = !skid_v[c][j];
            end
            up_rdy[REG_LENGTH] = m.ready[c];
            feed_v[0] = s.valid[c] & s_ready_q[c];
            feed_d[0] = s.data[c*DATA_WIDTH +: DATA_WIDTH];
            for (int j = 0; j < int'(REG_LENGTH); j++) begin
                feed_v[j+1] = main_v[c][j] & up_rdy[j+1];
                feed_d[j+1] = main_d[c][j];
            end
            for (int j = 0; j < int'(REG_LENGTH); j++) begin
                if (main_v[c][j] && !up_rdy[j+1]) begin
                    if (feed_v[j]) begin
                        skid_v_n[c][j] = 1'b1;
                        skid_d_n[c][j] = feed_d[j];
                    end
                end else if (skid_v[c][j]) begin
                    main_v_n[c][j] = 1'b1;
                    main_d_n[c][j] = skid_d[c][j];
                    skid_v_n[c][j] = 1'b0;
                end else begin
                    main_v_n[c][j] = feed_v[j];
                    if (feed_v[j]) begin
                        main_d_n[c][j] = feed_d[j];
                    end
                end
            end
        end
        if (flush_c) begin
            main_v_n = '0;
            skid_v_n = '0;
        end
        for (int c = 0; c < int'(CHANNELS); c++) begin
            busy_n[c]  = |(main_v_n[c] | skid_v_n[c]);
            skid0_n[c] = skid_v_n[c][0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v <= '0;
            skid_v <= '0;
            main_d <= '0;
            skid_d <= '0;
            busy   <= '0;
        end else begin
            main_v <= main_v_n;
            skid_v <= skid_v_n;
            main_d <= main_d_n;
            skid_d <= skid_d_n;
            busy   <= busy_n;
        end
    end

    // Decouple controller; the next state is RUN exactly when the request is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_RUN;
            drain_cnt     <= '0;
            drain_timeout <= 1'b0;
            decouple_ack  <= 1'b0;
            s_ready_q     <= '1;
        end else begin
            decouple_ack <= 1'b0;
            s_ready_q    <= {CHANNELS{!decouple_req}} & ~skid0_n;
            case (state)
                ST_RUN: begin
                    if (decouple_req) begin
                        state         <= ST_DRAIN;
                        drain_cnt     <= '0;
                        drain_timeout <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (!decouple_req) begin
                        state <= ST_RUN;
                    end else if (pipe_empty_c) begin
                        state        <= ST_ISOLATED;
                        decouple_ack <= 1'b1;
                    end else if (timeout_hit_c) begin
                        state         <= ST_ISOLATED;
                        decouple_ack  <= 1'b1;
                        drain_timeout <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                ST_ISOLATED: begin
                    if (!decouple_req) begin
                        state <= ST_RUN;
                    end else begin
                        decouple_ack <= 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign s.ready = s_ready_q;

    for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_out
        assign m.valid[c]                          = main_v[c][REG_LENGTH-1];
        assign m.data[c*DATA_WIDTH +: DATA_WIDTH]  = main_d[c][REG_LENGTH-1];
    end
endmodule

// File: tb/tb_pr_boundary_slice.sv
// Randomized bench for pr_boundary_slice: per-channel beat queues plus an abstract
// RUN/DRAIN/ISOLATED model predict every output beat, busy, ack and timeout flag.
module tb_pr_boundary_slice;
    localparam int unsigned DW = 32;
    localparam int unsigned CH = 4;
    localparam int unsigned RL = 2;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          decouple_req;
    logic          decouple_ack;
    logic          drain_timeout;
    logic [CH-1:0] busy;

    always #5 clk = ~clk;

    pr_boundary_slice_if #(.CHANNELS(CH), .DATA_WIDTH(DW)) s_if ();
    pr_boundary_slice_if #(.CHANNELS(CH), .DATA_WIDTH(DW)) m_if ();

    pr_boundary_slice #(
        .DATA_WIDTH(DW), .CHANNELS(CH), .REG_LENGTH(RL), .DRAIN_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s(s_if), .m(m_if),
        .decouple_req(decouple_req), .decouple_ack(decouple_ack),
        .drain_timeout(drain_timeout), .busy(busy)
    );

    typedef enum int {M_RUN, M_DRAIN, M_ISO} mstate_t;

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    logic [DW-1:0] q [CH][$];
    mstate_t       ms = M_RUN;
    int            mcnt = 0;
    bit            mflag = 1'b0;
    logic [CH-1:0] drv_valid = '0;
    logic [CH-1:0] drv_ready = '1;
    logic          drv_req = 1'b0;
    bit            rand_data = 1'b0;
    int unsigned   seqv [CH];
    int            acc_cnt [CH], del_cnt [CH];
    int            first_acc [CH], last_acc [CH], first_del [CH], last_del [CH];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_stats();
        for (int c = 0; c < int'(CH); c++) begin
            acc_cnt[c] = 0; del_cnt[c] = 0;
            first_acc[c] = -1; last_acc[c] = -1; first_del[c] = -1; last_del[c] = -1;
        end
    endtask

    // One clock: drive at negedge, compare against the model, then advance the model.
    task automatic cycle();
        logic [CH*DW-1:0] d;
        logic [CH-1:0]    exp_busy;
        bit               empty;
        @(negedge clk);
        for (int c = 0; c < int'(CH); c++)
            d[c*DW +: DW] = rand_data ? DW'($urandom) : DW'({8'(c), 24'(seqv[c])});
        s_if.data = d;
        s_if.valid = drv_valid;
        m_if.ready = drv_ready;
        decouple_req = drv_req;
        #1;
        cyc++;
        empty = 1'b1;
        for (int c = 0; c < int'(CH); c++) begin
            exp_busy[c] = (q[c].size() != 0);
            if (q[c].size() != 0) empty = 1'b0;
        end
        check("busy", 64'(busy), 64'(exp_busy));
        check("decouple_ack", 64'(decouple_ack), 64'(ms == M_ISO));
        check("drain_timeout", 64'(drain_timeout), 64'(mflag));
        if (ms != M_RUN) check("s_ready_off", 64'(s_if.ready), 64'(0));
        if (ms == M_ISO) check("m_valid_iso", 64'(m_if.valid), 64'(0));
        for (int c = 0; c < int'(CH); c++) begin
            if (m_if.valid[c]) begin
                if (q[c].size() == 0) begin
                    check($sformatf("spurious_beat_ch%0d", c), 64'(m_if.valid[c]), 64'(0));
                end else begin
                    check($sformatf("m_data_ch%0d", c), 64'(m_if.data[c*DW +: DW]), 64'(q[c][0]));
                    if (m_if.ready[c]) begin
                        void'(q[c].pop_front());
                        del_cnt[c]++;
                        if (first_del[c] < 0) first_del[c] = cyc;
                        last_del[c] = cyc;
                    end
                end
            end
            if (s_if.valid[c] && s_if.ready[c]) begin
                q[c].push_back(d[c*DW +: DW]);
                seqv[c]++;
                acc_cnt[c]++;
                if (first_acc[c] < 0) first_acc[c] = cyc;
                last_acc[c] = cyc;
            end
        end
        case (ms)
            M_RUN: if (decouple_req) begin ms = M_DRAIN; mcnt = 0; mflag = 1'b0; end
            M_DRAIN: begin
                if (!decouple_req) ms = M_RUN;
                else if (empty) ms = M_ISO;
                else if (mcnt == int'(TO) - 1) begin
                    for (int c = 0; c < int'(CH); c++) q[c].delete();
                    mflag = 1'b1;
                    ms = M_ISO;
                end else mcnt++;
            end
            default: if (!decouple_req) ms = M_RUN;
        endcase
    endtask

    task automatic settle(input int n);
        drv_valid = '0;
        drv_ready = '1;
        repeat (n) cycle();
    endtask

    task automatic random_traffic(input int n);
        rand_data = 1'b1;
        repeat (n) begin
            drv_valid = CH'($urandom);
            drv_ready = CH'($urandom) | CH'($urandom);
            cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b0_cyc, ack_cyc, rise_cyc, n;
        for (int c = 0; c < int'(CH); c++) seqv[c] = 1;
        s_if.data = '0; s_if.valid = '0; m_if.ready = '1; decouple_req = 1'b0;
        clear_stats();
        repeat (2) @(negedge clk);
        check("rst_m_valid", 64'(m_if.valid), 64'(0));
        check("rst_m_data", 64'(m_if.data), 64'(0));
        check("rst_s_ready", 64'(s_if.ready), 64'({CH{1'b1}}));
        check("rst_ack", 64'(decouple_ack), 64'(0));
        check("rst_timeout", 64'(drain_timeout), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        rst_n = 1'b1;

        // Sixteen sequential beats on ch0 with downstream always ready.
        n = 0;
        while (acc_cnt[0] < 16 && n < 40) begin
            drv_valid = (acc_cnt[0] < 15 || n == 0) ? 4'b0001 : 4'b0001;
            cycle();
            n++;
        end
        settle(6);
        check("ch0_latency", 64'(first_del[0] - first_acc[0]), 64'(RL));
        check("ch0_delivered", 64'(del_cnt[0]), 64'(16));
        check("ch0_accept_no_bubble", 64'(last_acc[0] - first_acc[0]), 64'(15));
        check("ch0_deliver_no_bubble", 64'(last_del[0] - first_del[0]), 64'(15));

        // Ch1 stalled for 5 cycles while every channel streams.
        clear_stats();
        rand_data = 1'b1;
        drv_valid = '1;
        drv_ready = 4'b1101;
        repeat (5) cycle();
        check("ch1_s_ready_stalled", 64'(s_if.ready[1]), 64'(0));
        check("ch1_accepted", 64'(acc_cnt[1]), 64'(2 * RL));
        check("ch1_held", 64'(q[1].size()), 64'(2 * RL));
        check("ch0_full_rate", 64'(acc_cnt[0]), 64'(5));
        check("ch2_full_rate", 64'(acc_cnt[2]), 64'(5));
        check("ch3_full_rate", 64'(acc_cnt[3]), 64'(5));
        settle(10);
        check("ch1_released", 64'(del_cnt[1]), 64'(2 * RL));

        // Three beats parked on ch2, then a clean drain with a same-cycle beat on ch0.
        clear_stats();
        drv_valid = 4'b0100;
        drv_ready = 4'b1011;
        n = 0;
        while (acc_cnt[2] < 3 && n < 20) begin cycle(); n++; end
        drv_valid = '0;
        check("ch2_parked", 64'(q[2].size()), 64'(3));
        drv_req = 1'b1;
        drv_ready = '1;
        drv_valid = 4'b0001;
        cycle();
        check("same_cycle_accept", 64'(acc_cnt[0]), 64'(1));
        drv_valid = '0;
        b0_cyc = -1; ack_cyc = -1; n = 0;
        while (ack_cyc < 0 && n < 30) begin
            cycle();
            if (busy == '0 && b0_cyc < 0) b0_cyc = cyc;
            if (decouple_ack) ack_cyc = cyc;
            n++;
        end
        check("drain_ack_seen", 64'(decouple_ack), 64'(1));
        check("ack_after_empty", 64'(ack_cyc - b0_cyc), 64'(1));
        check("drain_no_timeout", 64'(drain_timeout), 64'(0));
        check("ch2_drained", 64'(del_cnt[2]), 64'(3));
        check("ch0_drained", 64'(del_cnt[0]), 64'(1));

        // Isolated: inputs are garbage and must be ignored.
        repeat (20) begin
            drv_valid = CH'($urandom) | 4'b0001;
            cycle();
        end
        drv_valid = '0;
        drv_req = 1'b0;
        cycle();
        cycle();
        check("run_s_ready", 64'(s_if.ready), 64'({CH{1'b1}}));
        random_traffic(250);
        settle(12);

        // Forced flush: ch3 never ready with two beats parked.
        clear_stats();
        drv_valid = 4'b1000;
        drv_ready = 4'b0111;
        n = 0;
        while (acc_cnt[3] < 2 && n < 20) begin cycle(); n++; end
        drv_valid = '0;
        drv_req = 1'b1;
        cycle();
        rise_cyc = cyc;
        ack_cyc = -1; n = 0;
        while (ack_cyc < 0 && n < 40) begin
            cycle();
            if (decouple_ack) ack_cyc = cyc;
            n++;
        end
        check("timeout_ack_seen", 64'(decouple_ack), 64'(1));
        check("timeout_drain_cycles", 64'(ack_cyc - (rise_cyc + 1)), 64'(TO));
        check("timeout_flag", 64'(drain_timeout), 64'(1));
        check("timeout_busy", 64'(busy), 64'(0));
        check("timeout_m_valid", 64'(m_if.valid), 64'(0));
        drv_req = 1'b0;
        cycle();
        cycle();
        check("timeout_run_s_ready", 64'(s_if.ready), 64'({CH{1'b1}}));
        check("timeout_flag_sticky", 64'(drain_timeout), 64'(1));
        settle(4);

        // Asynchronous reset in the middle of a burst.
        rand_data = 1'b1;
        repeat (15) begin
            drv_valid = '1;
            drv_ready = CH'($urandom);
            cycle();
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_m_valid", 64'(m_if.valid), 64'(0));
        check("async_rst_busy", 64'(busy), 64'(0));
        for (int c = 0; c < int'(CH); c++) q[c].delete();
        ms = M_RUN; mflag = 1'b0;
        s_if.valid = '0; drv_valid = '0; drv_req = 1'b0; decouple_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("post_rst_s_ready", 64'(s_if.ready), 64'({CH{1'b1}}));
        check("post_rst_m_data", 64'(m_if.data), 64'(0));
        random_traffic(200);
        settle(12);
        n = 0;
        for (int c = 0; c < int'(CH); c++) n += q[c].size();
        check("final_model_empty", 64'(n), 64'(0));
        check("final_busy", 64'(busy), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
